// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, byte width
// and the width helper also used by the baud generator.
package uart_tx_scheduler_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: holds the priority pointer and picks the first pending
// requester at or after it, wrapping modulo N.
module rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] win_s;
    logic [IW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest pending requester wins.
    always_comb begin
        win_s  = ptr_r;
        cand_s = ptr_r;
        for (int i = N - 1; i >= 0; i--) begin
            cand_s = IW'((int'(ptr_r) + i) % N);
            win_s  = req[cand_s] ? cand_s : win_s;
        end
    end

    // Pointer moves to just past the winner whenever a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {IW{1'b0}};
        end else if (advance) begin
            ptr_r <= (win_s == IW'(N - 1)) ? {IW{1'b0}} : win_s + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt_idx = win_s;
    assign any     = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between NUM_REQ requesters with round-robin
// arbitration and serialises each granted frame as 8N1, LSB first.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_BYTES = 2,
    parameter int STOP_BITS   = 1,
    parameter int GAP_TICKS   = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*FRAME_BYTES*8-1:0]   frame_data,
    input  logic                               baud_tick,
    output logic                               baud_en,
    output logic                               txd,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int FW = FRAME_BYTES * DATA_BITS;
    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(FRAME_BYTES) + 1;
    localparam int TW = clog2(max_int(STOP_BITS, GAP_TICKS) + 1);

    tx_state_t        state_r, state_nx_s;
    logic [FW-1:0]    shift_r, shift_nx_s;
    logic [2:0]       bit_cnt_r, bit_cnt_nx_s;
    logic [BW-1:0]    byte_cnt_r, byte_cnt_nx_s;
    logic [TW-1:0]    tick_cnt_r, tick_cnt_nx_s;
    logic [IW-1:0]    win_idx_s;
    logic             any_s;
    logic             advance_s;
    logic             txd_r, txd_nx_s;
    logic             baud_en_r, baud_en_nx_s;
    logic             busy_r, busy_nx_s;
    logic             frame_done_r, frame_done_nx_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nx_s;

    assign advance_s = (state_r == IDLE) && any_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance_s),
        .gnt_idx (win_idx_s),
        .any     (any_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and datapath; a tick is always consumed by the current state.
    always_comb begin
        state_nx_s    = state_r;
        shift_nx_s    = shift_r;
        bit_cnt_nx_s  = bit_cnt_r;
        byte_cnt_nx_s = byte_cnt_r;
        tick_cnt_nx_s = tick_cnt_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nx_s    = START;
                    bit_cnt_nx_s  = 3'd0;
                    byte_cnt_nx_s = {BW{1'b0}};
                    tick_cnt_nx_s = {TW{1'b0}};
                    for (int i = 0; i < NUM_REQ; i++) begin
                        shift_nx_s = (win_idx_s == IW'(i)) ? frame_data[i*FW +: FW] : shift_nx_s;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nx_s   = DATA;
                    bit_cnt_nx_s = 3'd0;
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_nx_s   = shift_r >> 1;
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        state_nx_s    = STOP;
                        tick_cnt_nx_s = {TW{1'b0}};
                    end else begin
                        state_nx_s = DATA;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            STOP: begin
                if (baud_tick && (tick_cnt_r == TW'(STOP_BITS - 1))) begin
                    tick_cnt_nx_s = {TW{1'b0}};
                    if (byte_cnt_r != BW'(FRAME_BYTES - 1)) begin
                        state_nx_s    = START;
                        byte_cnt_nx_s = byte_cnt_r + BW'(1);
                    end else if (GAP_TICKS > 0) begin
                        state_nx_s = GAP;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else if (baud_tick) begin
                    tick_cnt_nx_s = tick_cnt_r + TW'(1);
                end else begin
                    state_nx_s = STOP;
                end
            end
            GAP: begin
                if (baud_tick && (tick_cnt_r == TW'(GAP_TICKS - 1))) begin
                    state_nx_s = IDLE;
                end else if (baud_tick) begin
                    tick_cnt_nx_s = tick_cnt_r + TW'(1);
                end else begin
                    state_nx_s = GAP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so they can be registered glitch-free.
    always_comb begin
        case (state_nx_s)
            START:   txd_nx_s = 1'b0;
            DATA:    txd_nx_s = shift_nx_s[0];
            default: txd_nx_s = 1'b1;
        endcase
        baud_en_nx_s    = (state_nx_s != IDLE);
        busy_nx_s       = (state_nx_s != IDLE);
        frame_done_nx_s = (state_r != IDLE) && (state_nx_s == IDLE);
        gnt_nx_s        = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_nx_s[i] = advance_s && (win_idx_s == IW'(i));
        end
    end

    // Shift register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= {FW{1'b0}};
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= {BW{1'b0}};
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            shift_r    <= shift_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            byte_cnt_r <= byte_cnt_nx_s;
            tick_cnt_r <= tick_cnt_nx_s;
        end
    end

    // Output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_r        <= 1'b1;
            baud_en_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            gnt_r        <= {NUM_REQ{1'b0}};
        end else begin
            txd_r        <= txd_nx_s;
            baud_en_r    <= baud_en_nx_s;
            busy_r       <= busy_nx_s;
            frame_done_r <= frame_done_nx_s;
            gnt_r        <= gnt_nx_s;
        end
    end

    assign txd        = txd_r;
    assign baud_en    = baud_en_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign gnt        = gnt_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: two schedulers (1 stop/no gap and 2 stop/3 gap bits) fed
// by a modelled baud generator, checked against a bit-level frame model.
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int FW = 16;
    localparam int TP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic spur = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*FW-1:0] frame_data = '0;

    logic [NR-1:0] req_a, req_b, gnt_a, gnt_b, gnt_m;
    logic tick_a, tick_b, be_a, be_b, txd_a, txd_b, busy_a, busy_b, fd_a, fd_b;
    logic txd_m, be_m, busy_m, fd_m;
    int cnt_a, cnt_b;
    int n_checks = 0;
    int n_fail = 0;
    int mptr_a = 0;
    int mptr_b = 0;

    always #5 clk = ~clk;

    assign req_a = sel ? '0 : req;
    assign req_b = sel ? req : '0;
    assign txd_m  = sel ? txd_b  : txd_a;
    assign be_m   = sel ? be_b   : be_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign fd_m   = sel ? fd_b   : fd_a;
    assign gnt_m  = sel ? gnt_b  : gnt_a;

    uart_tx_scheduler #(.NUM_REQ(NR), .FRAME_BYTES(2), .STOP_BITS(1), .GAP_TICKS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .frame_data(frame_data), .baud_tick(tick_a),
        .baud_en(be_a), .txd(txd_a), .gnt(gnt_a), .busy(busy_a), .frame_done(fd_a)
    );

    uart_tx_scheduler #(.NUM_REQ(NR), .FRAME_BYTES(2), .STOP_BITS(2), .GAP_TICKS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .frame_data(frame_data), .baud_tick(tick_b),
        .baud_en(be_b), .txd(txd_b), .gnt(gnt_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Baud generator model: phase held at zero while disabled, tick every TP cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_a <= 0;
        else if (!be_a || cnt_a == TP - 1) cnt_a <= 0;
        else cnt_a <= cnt_a + 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_b <= 0;
        else if (!be_b || cnt_b == TP - 1) cnt_b <= 0;
        else cnt_b <= cnt_b + 1;
    end
    assign tick_a = (be_a && cnt_a == TP - 1) || spur;
    assign tick_b = be_b && cnt_b == TP - 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int p, input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // One full frame: grant, every line bit at mid-bit, then the end-of-frame pulse.
    task automatic do_frame(input logic [NR-1:0] req_v, input logic [NR-1:0] next_req);
        int stop_n, gap_n, w, p;
        logic [FW-1:0] word;
        bit bits[$];
        stop_n = sel ? 2 : 1;
        gap_n  = sel ? 3 : 0;
        p = sel ? mptr_b : mptr_a;
        w = pick(p, req_v);
        word = frame_data[w*FW +: FW];
        bits.delete();
        for (int b = 0; b < 2; b++) begin
            bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) bits.push_back(word[b*8 + j]);
            for (int s = 0; s < stop_n; s++) bits.push_back(1'b1);
        end
        for (int g = 0; g < gap_n; g++) bits.push_back(1'b1);
        req = req_v;
        step();
        check_eq("gnt", 32'(gnt_m), 32'(4'b0001 << w));
        check_eq("txd_at_grant", 32'(txd_m), 32'd0);
        check_eq("busy_at_grant", 32'(busy_m), 32'd1);
        check_eq("baud_en_at_grant", 32'(be_m), 32'd1);
        check_eq("frame_done_at_grant", 32'(fd_m), 32'd0);
        if (sel) mptr_b = (w + 1) % NR;
        else mptr_a = (w + 1) % NR;
        req = next_req;
        repeat (8) step();
        for (int i = 0; i < bits.size(); i++) begin
            if (i > 0) repeat (TP) step();
            check_eq($sformatf("bit%0d", i), 32'(txd_m), 32'(bits[i]));
            if (i % 5 == 0) begin
                check_eq("busy_mid", 32'(busy_m), 32'd1);
                check_eq("gnt_mid", 32'(gnt_m), 32'd0);
            end
        end
        repeat (8) step();
        check_eq("frame_done", 32'(fd_m), 32'd1);
        check_eq("busy_end", 32'(busy_m), 32'd0);
        check_eq("baud_en_end", 32'(be_m), 32'd0);
        check_eq("txd_end", 32'(txd_m), 32'd1);
    endtask

    initial begin
        logic [NR-1:0] r, nxt;
        int w;

        // Reset values.
        repeat (3) step();
        check_eq("rst_txd", 32'(txd_a), 32'd1);
        check_eq("rst_baud_en", 32'(be_a), 32'd0);
        check_eq("rst_gnt", 32'(gnt_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_frame_done", 32'(fd_a), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Spurious tick in IDLE is ignored.
        spur = 1'b1;
        step();
        spur = 1'b0;
        check_eq("spur_txd", 32'(txd_a), 32'd1);
        repeat (3) step();
        check_eq("spur_busy", 32'(busy_a), 32'd0);
        check_eq("spur_baud_en", 32'(be_a), 32'd0);

        // Single request from requester 2.
        frame_data[2*FW +: FW] = 16'hA55A;
        do_frame(4'b0100, 4'b0000);

        // Pointer wrap with requesters 0 and 3 held.
        do_frame(4'b1001, 4'b1001);
        do_frame(4'b1001, 4'b1001);
        do_frame(4'b1001, 4'b0000);

        // Randomised requests and data.
        r = 4'b0000;
        for (int it = 0; it < 6; it++) begin
            if (r == 4'b0000) r = 4'($urandom_range(1, 15));
            frame_data = {$urandom, $urandom};
            w = pick(mptr_a, r);
            nxt = (r & ~(4'b0001 << w)) | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            do_frame(r, nxt);
            r = nxt;
        end
        req = 4'b0000;
        step();

        // Reset in the middle of data bit 4.
        frame_data = {$urandom, $urandom};
        w = pick(mptr_a, 4'b0010);
        req = 4'b0010;
        step();
        check_eq("mid_rst_gnt", 32'(gnt_a), 32'(4'b0001 << w));
        req = 4'b0000;
        repeat (8 + TP * 5) step();
        check_eq("mid_rst_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_txd", 32'(txd_a), 32'd1);
        check_eq("mid_rst_baud_en", 32'(be_a), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
        mptr_a = 0;
        mptr_b = 0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (10) step();
            check_eq("post_rst_txd", 32'(txd_a), 32'd1);
            check_eq("post_rst_busy", 32'(busy_a), 32'd0);
        end

        // All requesting from a fresh pointer: 0,1,2,3,0.
        frame_data = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) do_frame(4'b1111, 4'b1111);
        do_frame(4'b1111, 4'b0000);

        // Two stop bits and three gap ticks on the second instance.
        sel = 1'b1;
        step();
        frame_data[0 +: FW] = 16'h00FF;
        do_frame(4'b0001, 4'b0000);
        frame_data = {$urandom, $urandom};
        do_frame(4'($urandom_range(1, 15)), 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
